// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and its helpers.
// State encoding and the default START timeout budget.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or
// after the pointer, searching upward with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        int j;
        valid = |req;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                idx   = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NREQ producers;
// one byte per grant, busy tracked through a 2-flop synchronizer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk_CPU,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [8*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    input  logic                     uart_busy,
    output logic                     uart_send,
    output logic [7:0]               uart_data,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     active
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          busy_m;
    logic          busy_s;
    logic [1:0]    sync_vld;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          tmo;
    logic          send_nx;
    logic [NREQ-1:0] ack_nx;
    logic          err_nx;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // busy_s is meaningless until both sync flops hold a real sample
    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            busy_m   <= 1'b0;
            busy_s   <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            busy_m   <= uart_busy;
            busy_s   <= busy_m;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign grant = (state == ST_IDLE) && pick_valid
                && sync_vld[1] && !busy_s;
    assign tmo   = (state == ST_START) && !busy_s
                && (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (grant) state_nx = ST_START;
            ST_START: begin
                if (busy_s)   state_nx = ST_WAIT;
                else if (tmo) state_nx = ST_DONE;
            end
            ST_WAIT:  if (!busy_s) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        send_nx = (state_nx == ST_START);
        ack_nx  = '0;
        if (state_nx == ST_DONE) ack_nx = NREQ'(1) << owner;
        err_nx  = tmo;
    end

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            uart_send <= 1'b0;
            uart_data <= 8'h00;
            ack       <= '0;
            err       <= 1'b0;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            uart_send <= send_nx;
            ack       <= ack_nx;
            err       <= err_nx;
            if (grant) begin
                owner     <= pick_idx;
                uart_data <= req_data[int'(pick_idx)*8 +: 8];
                cnt       <= '0;
            end else if (state == ST_START && !busy_s && !tmo) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_DONE) begin
                if (owner == IW'(NREQ - 1)) ptr <= '0;
                else                        ptr <= owner + 1'b1;
            end
        end
    end

    assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model;
// every comparison is an immediate assertion with a failure count.
module tb_uart_tx_arbiter;

    logic       clk_CPU;
    logic       rst_n;
    logic [3:0] req;
    logic [31:0] req_data;
    logic [3:0] ack;
    logic       err;
    logic       uart_busy;
    logic       uart_send;
    logic [7:0] uart_data;
    logic [1:0] owner;
    logic       active;

    logic       model_en;
    logic       busy_model;
    logic       busy_force;
    int         ph;
    int         mc;

    int n_assert;
    int n_fail;

    uart_tx_arbiter #(
        .NREQ    (4),
        .TIMEOUT (15)
    ) dut (
        .clk_CPU   (clk_CPU),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .err       (err),
        .uart_busy (uart_busy),
        .uart_send (uart_send),
        .uart_data (uart_data),
        .owner     (owner),
        .active    (active)
    );

    initial clk_CPU = 1'b0;
    always #5 clk_CPU = ~clk_CPU;

    assign uart_busy = model_en ? busy_model : busy_force;

    // UART model: busy rises 3 cycles after send is seen, holds 20 cycles
    always @(posedge clk_CPU) begin
        if (!model_en) begin
            ph         <= 0;
            mc         <= 0;
            busy_model <= 1'b0;
        end else begin
            case (ph)
                0: if (uart_send) begin
                    ph <= 1;
                    mc <= 1;
                end
                1: if (mc == 3) begin
                    busy_model <= 1'b1;
                    ph         <= 2;
                    mc         <= 1;
                end else mc <= mc + 1;
                default: if (mc == 20) begin
                    busy_model <= 1'b0;
                    ph         <= 0;
                end else mc <= mc + 1;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_CPU);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int max, output logic [3:0] a,
                            output logic e);
        a = '0;
        e = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (ack != '0) begin
                a = ack;
                e = err;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] a;
        logic       e;
        int         hi;
        int         viol;
        int         x;

        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        model_en   = 1'b0;
        busy_force = 1'b0;

        #3;
        check("rst_send", 32'(uart_send), 0);
        check("rst_data", 32'(uart_data), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_active", 32'(active), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // single request
        model_en = 1'b1;
        req_data = 32'h0000_0041;
        req      = 4'b0001;
        tick(1);
        check("t1_send", 32'(uart_send), 1);
        check("t1_data", 32'(uart_data), 32'h41);
        check("t1_owner", 32'(owner), 0);
        check("t1_active", 32'(active), 1);
        wait_ack(100, a, e);
        check("t1_ack", 32'(a), 32'b0001);
        check("t1_err", 32'(e), 0);
        check("t1_data_done", 32'(uart_data), 32'h41);
        check("t1_send_done", 32'(uart_send), 0);
        req = '0;
        tick(1);
        check("t1_ack_pulse", 32'(ack), 0);

        // round robin from pointer 0
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        req_data = 32'h1312_1110;
        req      = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            x = i % 4;
            wait_ack(100, a, e);
            check("t2_ack", 32'(a), 32'(1) << x);
            check("t2_owner", 32'(owner), 32'(x));
            check("t2_data", 32'(uart_data), 32'h10 + 32'(x));
            check("t2_err", 32'(e), 0);
        end
        req = 4'b0010;
        wait_ack(100, a, e);
        check("t2_ack_p1", 32'(a), 32'b0010);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            x = (i + 2) % 4;
            wait_ack(100, a, e);
            check("t2b_ack", 32'(a), 32'(1) << x);
            check("t2b_data", 32'(uart_data), 32'h10 + 32'(x));
        end
        req = '0;
        tick(1);
        check("t2_ack_pulse", 32'(ack), 0);

        // start timeout with busy stuck low
        model_en   = 1'b0;
        busy_force = 1'b0;
        req        = 4'b0100;
        tick(1);
        check("t3_send", 32'(uart_send), 1);
        check("t3_owner", 32'(owner), 2);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (uart_send) hi++;
            else break;
        end
        check("t3_send_cycles", 32'(hi), 16);
        check("t3_ack", 32'(ack), 32'b0100);
        check("t3_err", 32'(err), 1);
        req = 4'b1111;
        tick(1);
        check("t3_ack_pulse", 32'(ack), 0);
        check("t3_err_pulse", 32'(err), 0);
        tick(1);
        check("t3_ptr_owner", 32'(owner), 3);
        check("t3_ptr_send", 32'(uart_send), 1);
        wait_ack(100, a, e);
        check("t3_ack3", 32'(a), 32'b1000);
        check("t3_err3", 32'(e), 1);
        req = '0;
        tick(1);

        // busy already high at reset release
        rst_n      = 1'b0;
        busy_force = 1'b1;
        req        = 4'b0010;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("t4_hold_send", 32'(uart_send), 0);
        check("t4_hold_active", 32'(active), 0);
        busy_force = 1'b0;
        tick(2);
        check("t4_sync_send", 32'(uart_send), 0);
        tick(1);
        check("t4_send", 32'(uart_send), 1);
        check("t4_owner", 32'(owner), 1);
        model_en = 1'b1;
        wait_ack(100, a, e);
        check("t4_ack", 32'(a), 32'b0010);
        check("t4_err", 32'(e), 0);
        req = '0;
        tick(1);

        // reset while waiting for the UART to finish
        req = 4'b0010;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (active && !uart_send && uart_busy) break;
        end
        check("t5_in_wait", 32'(active && !uart_send), 1);
        check("t5_owner_pre", 32'(owner), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_send", 32'(uart_send), 0);
        check("t5_rst_active", 32'(active), 0);
        check("t5_rst_owner", 32'(owner), 0);
        check("t5_rst_data", 32'(uart_data), 0);
        check("t5_rst_ack", 32'(ack), 0);
        tick(2);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (!uart_busy) break;
            if (uart_send || active) viol++;
        end
        check("t5_no_grant_busy", 32'(viol), 0);
        tick(2);
        check("t5_sync_send", 32'(uart_send), 0);
        tick(1);
        check("t5_send", 32'(uart_send), 1);
        check("t5_owner", 32'(owner), 1);
        wait_ack(100, a, e);
        check("t5_ack", 32'(a), 32'b0010);
        req = '0;
        tick(1);

        // request withdrawn after grant
        req = 4'b0010;
        tick(1);
        check("t6_send", 32'(uart_send), 1);
        check("t6_owner", 32'(owner), 1);
        tick(1);
        req = '0;
        wait_ack(100, a, e);
        check("t6_ack", 32'(a), 32'b0010);
        check("t6_err", 32'(e), 0);
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (uart_send || active || ack != '0) viol++;
        end
        check("t6_no_regrant", 32'(viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NREQ byte producers (CPU store path, debug/trace, DMA-style sources) using round-robin arbitration.
- Runs on the CPU clock and drives the UART `send` level and `DataOut` byte.
- Tracks the UART `busy` flag, which is generated on the baud clock, through a 2-flop synchronizer.
- Completes one byte per grant and acks the requester; flags a start timeout if the UART never goes busy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 65535, CPU cycles allowed in START before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk_CPU  in  1  system clock; all logic is posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until ack.
- req_data  in  8*NREQ  byte for requester i at [8i+7:8i].
- ack  out  NREQ  one-cycle pulse on the granted bit when its byte finishes or aborts.
- err  out  1  one-cycle pulse coincident with ack on a timeout abort.
- uart_busy  in  1  UART busy flag (asynchronous to clk_CPU).
- uart_send  out  1  level to UART `send`.
- uart_data  out  8  byte to UART `DataOut`; stable from grant until DONE.
- owner  out  $clog2(NREQ)  index of the current or last granted requester.
- active  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, uart_send=0, uart_data=0, ack=0, err=0, owner=0, active=0, rr pointer=0, busy synchronizer=0, timeout counter=0.
- busy_s is uart_busy after 2 flops; only busy_s is used by the logic.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the rr pointer, searching upward with wrap.
  - On the grant edge: latch owner and uart_data from that slice, set uart_send=1, clear the timeout counter, go to START.
  - Latency from req high (IDLE, UART idle) to uart_send high is 1 cycle.
- IDLE entry when busy_s=1 (UART still draining from elsewhere): do not grant; stay in IDLE until busy_s=0.
- START (uart_send=1):
  - When busy_s=1: uart_send=0, go to WAIT.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT: uart_send=0, go to DONE with an abort flag.
- WAIT (uart_send=0): when busy_s=0, go to DONE. No timeout in WAIT.
- DONE (1 cycle):
  - ack[owner]=1; err=abort flag.
  - rr pointer = owner+1, with wrap from NREQ-1 to 0.
  - Go to IDLE. A new grant is possible on the following cycle.
- Back-to-back:
  - uart_send is low for at least the whole WAIT phase before the next START.
  - This guarantees the UART's internal send latch re-arms between bytes.
- Req dropped after grant: the transfer still completes and ack still pulses. Requesters must not change req_data of a pending request.
- Simultaneous requests: strictly round-robin. A requester holding req continuously is served at most once per NREQ grants while the others are requesting.
- Reset mid-transfer: uart_send drops immediately (async). The UART may still finish the byte in flight; after reset the block waits in IDLE for busy_s=0 before granting.
- ack and err are registered outputs and never both high outside DONE.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_START=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3.
  - default TIMEOUT constant.
- One sub-module: rr_pick.
  - Combinational.
  - Inputs: req and pointer.
  - Outputs: a grant-valid bit and the index of the first set bit at or after the pointer.
  - Reused later by other shared-bus arbiters.
- The busy synchronizer stays inline in uart_tx_arbiter.

Test Plan:
1. Single request:
   - Stimulus: req=4'b0001, req_data[7:0]=8'h41, bench UART model raises busy 3 cycles after send and holds it 20 cycles.
   - Required: uart_data=8'h41; uart_send high 1 cycle after req until busy_s is seen; ack[0] pulses once; err=0; owner=0.
2. Round-robin fairness:
   - Stimulus: req=4'b1111 held with bytes 8'h10,8'h11,8'h12,8'h13.
   - Required: grants in order 0,1,2,3,0; each ack exactly one pulse.
   - Repeat starting with pointer=2: required grant order 2,3,0,1.
3. Timeout:
   - Stimulus: TIMEOUT=15, uart_busy stuck at 0, req=4'b0100.
   - Required: uart_send drops after 16 cycles in START; ack[2] and err pulse together; pointer becomes 3.
4. Busy at idle:
   - Stimulus: uart_busy=1 from reset release, req=4'b0010.
   - Required: no uart_send until 2 cycles after uart_busy falls; then normal transfer.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 in WAIT, release while uart_busy=1.
   - Required: all outputs return to reset values asynchronously; no grant until busy_s=0; previously pending requester is then served.
6. Req withdrawn:
   - Stimulus: drop req[1] one cycle after grant.
   - Required: byte still sent; ack[1] pulses; no second grant to 1.
